// File: rtl/clock_gate_ctrl_mc.sv
// Purpose: per-channel clock gating with idle timeout and a min-on hold after each wakeup.
// Latency: gates K+2 edges after the last wakeup edge; ungates combinationally on wakeup.
// Backpressure: none; wakeup and cfg_cg_enable always win over the idle countdown.
//
// Ports:
//   clk_in / aresetn   free-running clock, async active-low reset
//   cfg_cg_enable      per-channel gating enable (0 = never gate)
//   cfg_cg_idle_count  per-channel idle timeout K, channel i at [i*N +: N]
//   cfg_cg_min_on      shared hold length applied after leaving GATED
//   wakeup             per-channel activity request
//   clk_out            gated clock per channel
//   gating             1 = channel clock currently gated
//   wake_pulse         registered 1-cycle pulse on GATED->RUN
//   all_gated          AND of gating
module clock_gate_ctrl_mc #(
  parameter int NUM_CH          = 4,
  parameter int IDLE_CNTR_WIDTH = 4,
  parameter int MIN_ON_WIDTH    = 4
) (
  input  logic                                clk_in,
  input  logic                                aresetn,
  input  logic [NUM_CH-1:0]                   cfg_cg_enable,
  input  logic [NUM_CH*IDLE_CNTR_WIDTH-1:0]   cfg_cg_idle_count,
  input  logic [MIN_ON_WIDTH-1:0]             cfg_cg_min_on,
  input  logic [NUM_CH-1:0]                   wakeup,
  output logic [NUM_CH-1:0]                   clk_out,
  output logic [NUM_CH-1:0]                   gating,
  output logic [NUM_CH-1:0]                   wake_pulse,
  output logic                                all_gated
);

  localparam int N = IDLE_CNTR_WIDTH;
  localparam int M = MIN_ON_WIDTH;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t         state;
    logic [N-1:0]   idle_cnt;
    logic [M-1:0]   hold_cnt;
    logic           pulse_q;
    logic           icg_en;
    logic           wake_or_dis;
    logic [N-1:0]   k_cfg;

    assign k_cfg       = cfg_cg_idle_count[i*N +: N];
    assign wake_or_dis = wakeup[i] | ~cfg_cg_enable[i];

    // idle_cnt resets to 0 rather than K: RUN reloads it every cycle, so the
    // value is never consumed before the first reload.
    always_ff @(posedge clk_in or negedge aresetn) begin
      if (!aresetn) begin
        state    <= ST_RUN;
        idle_cnt <= '0;
        hold_cnt <= '0;
        pulse_q  <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state)
          ST_RUN: begin
            idle_cnt <= k_cfg;
            if (hold_cnt != '0)
              hold_cnt <= hold_cnt - {{(M-1){1'b0}}, 1'b1};
            // Hold is checked on its current value, so min_on=m keeps RUN for m extra edges.
            if (hold_cnt == '0 && !wake_or_dis)
              state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (wake_or_dis) begin
              state    <= ST_RUN;
              idle_cnt <= k_cfg;
            end else if (idle_cnt == '0) begin
              state <= ST_GATED;
            end else begin
              idle_cnt <= idle_cnt - {{(N-1){1'b0}}, 1'b1};
            end
          end
          ST_GATED: begin
            if (wake_or_dis) begin
              state    <= ST_RUN;
              hold_cnt <= cfg_cg_min_on;
              pulse_q  <= 1'b1;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end

    // Wakeup / disable ungate in the same cycle, before the FSM leaves GATED.
    assign gating[i]     = (state == ST_GATED) & ~wakeup[i] & cfg_cg_enable[i];
    assign wake_pulse[i] = pulse_q;

    // ICG: enable captured while clk_in is low so clk_out never glitches.
    // Reset forces the enable open so clocks return as soon as aresetn drops.
    always_ff @(negedge clk_in or negedge aresetn) begin
      if (!aresetn)
        icg_en <= 1'b1;
      else
        icg_en <= ~gating[i];
    end

    assign clk_out[i] = clk_in & icg_en;
  end

  assign all_gated = &gating;

endmodule

// File: tb/tb_clock_gate_ctrl_mc.sv
// Purpose: randomized check of clock_gate_ctrl_mc against a timestamp-based model.
// Latency: outputs sampled 1 time unit after posedge; combinational ungate after each drive.
// Backpressure: not applicable.
module tb_clock_gate_ctrl_mc;
  localparam int NCH  = 4;
  localparam int NW   = 4;
  localparam int MW   = 4;
  localparam int NCYC = 2000;

  logic               clk_in = 1'b0;
  logic               aresetn;
  logic [NCH-1:0]     cfg_cg_enable;
  logic [NCH*NW-1:0]  cfg_cg_idle_count;
  logic [MW-1:0]      cfg_cg_min_on;
  logic [NCH-1:0]     wakeup;
  logic [NCH-1:0]     clk_out;
  logic [NCH-1:0]     gating;
  logic [NCH-1:0]     wake_pulse;
  logic               all_gated;

  clock_gate_ctrl_mc #(.NUM_CH(NCH), .IDLE_CNTR_WIDTH(NW), .MIN_ON_WIDTH(MW)) dut (
    .clk_in(clk_in), .aresetn(aresetn), .cfg_cg_enable(cfg_cg_enable),
    .cfg_cg_idle_count(cfg_cg_idle_count), .cfg_cg_min_on(cfg_cg_min_on),
    .wakeup(wakeup), .clk_out(clk_out), .gating(gating),
    .wake_pulse(wake_pulse), .all_gated(all_gated)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc_g = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc_g);
    end
  endtask

  // Model: a channel is asleep or awake. When awake it may start counting
  // idle edges once the hold window has elapsed; a countdown started on edge s
  // with timeout K puts the channel to sleep on edge s+K+1 if no edge in between
  // saw wakeup or disable.
  bit           asleep  [NCH];
  bit           pulse_m [NCH];
  int           hold_end[NCH];
  int           start   [NCH];
  int           kk      [NCH];
  int           edge_n = 0;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      asleep[i] = 0; pulse_m[i] = 0; hold_end[i] = 0; start[i] = -1; kk[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit wd;
    for (int i = 0; i < NCH; i++) begin
      wd = wakeup[i] || !cfg_cg_enable[i];
      pulse_m[i] = 0;
      if (asleep[i]) begin
        if (wd) begin
          asleep[i]   = 0;
          pulse_m[i]  = 1;
          hold_end[i] = edge_n + int'(cfg_cg_min_on) + 1;
          start[i]    = -1;
        end
      end else if (wd) begin
        start[i] = -1;
      end else if (start[i] < 0) begin
        if (edge_n >= hold_end[i]) begin
          start[i] = edge_n;
          kk[i]    = int'(cfg_cg_idle_count[i*NW +: NW]);
        end
      end else if (edge_n == start[i] + kk[i] + 1) begin
        asleep[i] = 1;
        start[i]  = -1;
      end
    end
    edge_n++;
  endtask

  function automatic logic [NCH-1:0] gating_exp();
    logic [NCH-1:0] g;
    for (int i = 0; i < NCH; i++)
      g[i] = asleep[i] && !wakeup[i] && cfg_cg_enable[i];
    return g;
  endfunction

  function automatic logic [NCH-1:0] pulse_exp();
    logic [NCH-1:0] p;
    for (int i = 0; i < NCH; i++) p[i] = pulse_m[i];
    return p;
  endfunction

  initial begin
    logic [NCH-1:0] en_exp;
    logic [NCH-1:0] g;
    int rst_left;
    int prob;
    int since_rel;
    rst_left = 0;
    aresetn = 1'b0;
    cfg_cg_enable = '1;
    cfg_cg_idle_count = '0;
    cfg_cg_min_on = '0;
    wakeup = '0;
    model_reset();

    repeat (2) @(posedge clk_in);
    #2;
    chk("rst_gating", 32'(gating), 32'h0);
    chk("rst_pulse", 32'(wake_pulse), 32'h0);
    chk("rst_allg", 32'(all_gated), 32'h0);
    aresetn = 1'b1;
    en_exp = '1;
    since_rel = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      cyc_g = cyc;
      @(posedge clk_in);
      #1;
      if (!aresetn) begin
        chk("inrst_gating", 32'(gating), 32'h0);
        chk("inrst_clk", 32'(clk_out), 32'(4'hF));
      end else begin
        model_edge();
        g = gating_exp();
        chk("gating", 32'(gating), 32'(g));
        chk("wake_pulse", 32'(wake_pulse), 32'(pulse_exp()));
        chk("all_gated", 32'(all_gated), 32'(&g));
        chk("clk_out", 32'(clk_out), 32'(en_exp));
        // K=0, min_on=0, no wakeup: all channels gated exactly two edges after release.
        if (cyc < 2)
          chk("kzero_allg", 32'(all_gated), (cyc == 1) ? 32'h1 : 32'h0);
        since_rel++;
      end

      #1;
      if (cyc == 700 || cyc == 1500) begin
        aresetn  = 1'b0;
        rst_left = 3;
      end else if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) begin
          aresetn = 1'b1;
          model_reset();
        end
      end

      if (cyc >= 4) begin
        case ((cyc / 150) % 4)
          0: prob = 2;
          1: prob = 10;
          2: prob = 0;
          default: prob = 40;
        endcase
        for (int i = 0; i < NCH; i++) begin
          wakeup[i]        = ($urandom_range(0, 99) < prob);
          cfg_cg_enable[i] = ($urandom_range(0, 99) >= 3);
        end
        if ($urandom_range(0, 39) == 0)
          cfg_cg_idle_count[$urandom_range(0, NCH-1)*NW +: NW] = NW'($urandom_range(0, 6));
        if ($urandom_range(0, 59) == 0)
          cfg_cg_min_on = MW'($urandom_range(0, 7));
      end

      #1;
      if (!aresetn) begin
        // Asserting reset restores every clock while clk_in is still high.
        chk("arst_gating", 32'(gating), 32'h0);
        chk("arst_clk", 32'(clk_out), 32'(4'hF));
        en_exp = '1;
      end else begin
        g = gating_exp();
        chk("comb_gating", 32'(gating), 32'(g));
        en_exp = ~g;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
